mult_display_sequencer: RTL

Controller that sequences the multiplier-result display path. It accepts a 16-bit two's-complement product on a start handshake and splits it into sign and 16-bit magnitude. It then runs a 16-iteration serial binary-to-BCD (shift-add-3) conversion and presents five stable BCD digits plus sign to the 7-segment driver. It sits between the multiplier output and the display scan/decoder logic.

---
 rtl/mult_display_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mult_display_sequencer.sv
// Multiplier-result display sequencer: captures a signed 16-bit product, converts
// its magnitude to five BCD digits with a serial shift-add-3 loop, and holds sign/bcd stable.
module mult_display_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] mult_result,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [19:0] bcd,
  output logic        digits_valid
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  // Adds 3 to every nibble that is 5 or more; nibbles never carry into each other.
  function automatic logic [19:0] add3_digits(input logic [19:0] s);
    logic [19:0] r;
    r = 20'h00000;
    for (int i = 0; i < 5; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t      state_r, state_s;
  logic        neg_r, neg_s;
  logic [15:0] mag_r, mag_s;
  logic [19:0] scratch_r, scratch_s;
  logic [3:0]  count_r, count_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        sign_r, sign_s;
  logic [19:0] bcd_r, bcd_s;
  logic        valid_r, valid_s;
  logic [19:0] adj_s;
  logic [19:0] scratch_sh_s;
  logic [15:0] mag_sh_s;

  // Next-state and datapath: capture in IDLE, one shift-add-3 iteration per CONVERT cycle.
  always_comb begin
    state_s   = state_r;
    neg_s     = neg_r;
    mag_s     = mag_r;
    scratch_s = scratch_r;
    count_s   = count_r;
    done_s    = 1'b0;
    sign_s    = sign_r;
    bcd_s     = bcd_r;
    valid_s   = valid_r;
    adj_s     = add3_digits(scratch_r);
    {scratch_sh_s, mag_sh_s} = {adj_s, mag_r} << 6'd1;
    case (state_r)
      IDLE: begin
        if (start) begin
          neg_s     = mult_result[15];
          // 0x8000 negates to itself, which read unsigned is the required 32768.
          mag_s     = mult_result[15] ? (~mult_result + 16'd1) : mult_result;
          scratch_s = 20'h00000;
          count_s   = 4'd0;
          state_s   = CONVERT;
        end else begin
          state_s = IDLE;
        end
      end
      CONVERT: begin
        scratch_s = scratch_sh_s;
        mag_s     = mag_sh_s;
        count_s   = count_r + 4'd1;
        if (count_r == 4'd15) begin
          bcd_s   = scratch_sh_s;
          sign_s  = neg_r;
          done_s  = 1'b1;
          valid_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = CONVERT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == CONVERT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      neg_r     <= 1'b0;
      mag_r     <= 16'h0000;
      scratch_r <= 20'h00000;
      count_r   <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sign_r    <= 1'b0;
      bcd_r     <= 20'h00000;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      neg_r     <= neg_s;
      mag_r     <= mag_s;
      scratch_r <= scratch_s;
      count_r   <= count_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      sign_r    <= sign_s;
      bcd_r     <= bcd_s;
      valid_r   <= valid_s;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign sign         = sign_r;
  assign bcd          = bcd_r;
  assign digits_valid = valid_r;

endmodule
